ram_port_arbiter: RTL

Two-requester arbiter and sequencer for the single-port data RAM (10-bit word address, 32-bit data, synchronous read). It sits between the memory/IO bus and the RAM. It shares the RAM between the CPU-side bus request path and a debug/loader port used for memory inspection and program download. It also generates the CPU-side ready signal that feeds the CPU's memory-ready input.

---
 rtl/ram_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous-read RAM between a CPU bus port and a debug/loader port.
// Latency: write ack 2 cycles after the request is seen in IDLE, read ack 2+RD_LAT cycles; rdata valid with ack.
// Backpressure: requesters hold req until their one-cycle ready/ack; a losing requester simply stays pending.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request (held until cpu_ready), cpu_rdata/cpu_ready response
//   dbg_req/we/addr/wdata         debug request (held until dbg_ack), dbg_rdata/dbg_ack response
//   ram_addr/ram_we/ram_din       RAM command side, ram_dout RAM read data (RD_LAT cycles after address)
//   owner                         requester holding the RAM: 00 none, 01 CPU, 10 debug
// Build option: define RAM_ARB_RR_EN for round-robin contention; otherwise the CPU has fixed priority.

module ram_port_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE} state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

  // WAIT counts down from RD_LAT-1; the cycle where it reads zero is the one
  // in which ram_dout carries the addressed word.
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          any_req;
  logic          dbg_wins;

  assign any_req = cpu_req | dbg_req;

`ifdef RAM_ARB_RR_EN
  // 1 = debug was served last, so the CPU takes the next contention.
  logic last_dbg_q, last_dbg_d;

  always_comb begin
    dbg_wins = dbg_req && (!cpu_req || !last_dbg_q);
  end

  always_comb begin
    last_dbg_d = last_dbg_q;
    if (state_q == S_IDLE && any_req) begin
      last_dbg_d = dbg_wins;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dbg_q <= 1'b1;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end
`else
  // Fixed priority: debug only wins when the CPU is not asking.
  always_comb begin
    dbg_wins = dbg_req && !cpu_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // Request fields are captured only here; later changes are ignored.
          state_d = S_GRANT;
          if (dbg_wins) begin
            owner_d = OWN_DBG;
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            owner_d = OWN_CPU;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      S_GRANT: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_DONE;
          if (owner_q == OWN_DBG) begin
            dbg_rdata_d = ram_dout;
          end else begin
            cpu_rdata_d = ram_dout;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 2'd0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // The latched address/data double as the RAM command registers, so they
  // naturally hold their last value whenever no access is in progress.
  assign ram_addr  = addr_q;
  assign ram_din   = wdata_q;
  assign ram_we    = (state_q == S_GRANT) && we_q;
  assign cpu_ready = (state_q == S_DONE) && (owner_q == OWN_CPU);
  assign dbg_ack   = (state_q == S_DONE) && (owner_q == OWN_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign owner     = owner_q;

endmodule
